// File: rtl/hub75_scan_ctrl.sv
// HUB75 32x32 scan controller: free-running column shift, blank, latch and
// display sequencing over a double-buffered frame memory.
module hub75_scan_ctrl #(
    parameter int ON_CYCLES    = 64,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       frame_done,
    output logic       buf_sel,
    output logic [9:0] rd_addr,
    input  logic [5:0] rd_data,
    output logic       r1,
    output logic       g1,
    output logic       b1,
    output logic       r2,
    output logic       g2,
    output logic       b2,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       lat,
    output logic       oe,
    output logic       led_clk
);

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

    localparam logic [9:0] SHIFT_LAST = 10'd65;
    localparam logic [9:0] BLANK_LAST = 10'(BLANK_CYCLES - 1);
    localparam logic [9:0] ON_LAST    = 10'(ON_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [9:0] cnt;
    logic [3:0] row;
    logic [3:0] row_out;
    logic [5:0] colour;
    logic       buf_q;
    logic       row_last;
    logic       frame_end;
    logic [4:0] col;

    assign row_last  = (state == DISPLAY) && (cnt == ON_LAST);
    assign frame_end = row_last && (row == 4'd15);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = SHIFT;
            SHIFT:   if (cnt == SHIFT_LAST) state_next = BLANK;
            BLANK:   if (cnt == BLANK_LAST) state_next = LATCH;
            LATCH:   state_next = DISPLAY;
            DISPLAY: begin
                if (row_last) begin
                    state_next = (row != 4'd15 || enable) ? SHIFT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt     <= '0;
            row     <= '0;
            row_out <= '0;
            colour  <= '0;
            buf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    row     <= '0;
                    row_out <= '0;
                    colour  <= '0;
                end
                SHIFT: begin
                    // Odd steps capture the word addressed on the previous even step.
                    if (cnt[0] && cnt < 10'd64) colour <= rd_data;
                    if (cnt == SHIFT_LAST) begin
                        cnt     <= '0;
                        row_out <= row;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                BLANK: begin
                    cnt <= (cnt == BLANK_LAST) ? '0 : cnt + 10'd1;
                end
                LATCH: begin
                    cnt    <= '0;
                    colour <= '0;
                end
                DISPLAY: begin
                    if (row_last) begin
                        cnt <= '0;
                        row <= row + 4'd1;
                        if (frame_end && swap_req) buf_q <= ~buf_q;
                        if (frame_end && !enable) row_out <= '0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign col        = (state == SHIFT) ? cnt[5:1] : '0;
    assign rd_addr    = {buf_q, row, col};
    assign buf_sel    = buf_q;
    assign frame_done = frame_end;
    assign swap_ack   = frame_end && swap_req;
    assign led_clk    = (state == SHIFT) && cnt[0] && (cnt >= 10'd3);
    assign lat        = (state == LATCH);
    assign oe         = (state != DISPLAY);
    assign {r1, g1, b1, r2, g2, b2} = colour;
    assign {d, c, b, a} = row_out;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: two instances (default and minimum timing) checked
// every cycle against a frame-position model, plus literal timing expectations.
module tb_hub75_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic enable;
    logic swap_req;
    logic checking;

    logic [5:0] mem [2][16][32];
    logic [1:0][5:0] rdata;

    wire [1:0][9:0] addr;
    wire [1:0][5:0] col;
    wire [1:0][3:0] ad;
    wire [1:0] ack, fd, bsel, lat, oe, led;

    int errors = 0;
    int checks = 0;

    hub75_scan_ctrl #(.ON_CYCLES(64), .BLANK_CYCLES(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .swap_req(swap_req),
        .swap_ack(ack[0]), .frame_done(fd[0]), .buf_sel(bsel[0]),
        .rd_addr(addr[0]), .rd_data(rdata[0]),
        .r1(col[0][5]), .g1(col[0][4]), .b1(col[0][3]),
        .r2(col[0][2]), .g2(col[0][1]), .b2(col[0][0]),
        .a(ad[0][0]), .b(ad[0][1]), .c(ad[0][2]), .d(ad[0][3]),
        .lat(lat[0]), .oe(oe[0]), .led_clk(led[0])
    );

    hub75_scan_ctrl #(.ON_CYCLES(1), .BLANK_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .swap_req(swap_req),
        .swap_ack(ack[1]), .frame_done(fd[1]), .buf_sel(bsel[1]),
        .rd_addr(addr[1]), .rd_data(rdata[1]),
        .r1(col[1][5]), .g1(col[1][4]), .b1(col[1][3]),
        .r2(col[1][2]), .g2(col[1][1]), .b2(col[1][0]),
        .a(ad[1][0]), .b(ad[1][1]), .c(ad[1][2]), .d(ad[1][3]),
        .lat(lat[1]), .oe(oe[1]), .led_clk(led[1])
    );

    // Frame memory with one cycle of read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            rdata[i] <= mem[addr[i][9]][addr[i][8:5]][addr[i][4:0]];
    end

    task automatic chk(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d actual=%0d required=%0d at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout actual=expired required=event at %0t", name, $time);
    endtask

    // Model: row period = 66 shift + blank + 1 latch + on cycles.
    int PER [2] = '{133, 69};
    int BLK [2] = '{2, 1};
    logic       m_run [2];
    int         m_p   [2];
    logic       m_buf [2];
    logic [3:0] m_ad  [2];

    int per, bl, r, q;
    logic       e_oe, e_lat, e_led, e_fd, e_ack, do_addr;
    logic [3:0] e_ad;
    logic [5:0] e_col;
    logic [9:0] e_addr;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 1'b0; m_p[i] = 0; m_buf[i] = 1'b0; m_ad[i] = '0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                per = PER[i];
                bl  = BLK[i];
                e_oe = 1'b1; e_lat = 1'b0; e_led = 1'b0; e_fd = 1'b0;
                e_ad = '0; e_col = '0; do_addr = 1'b0; e_addr = '0;
                if (!m_run[i]) begin
                    do_addr = 1'b1;
                    e_addr  = {m_buf[i], 9'd0};
                end else begin
                    r = m_p[i] / per;
                    q = m_p[i] % per;
                    if (q < 66) begin
                        e_ad  = m_ad[i];
                        e_led = (q % 2 == 1) && (q >= 3);
                        if (q >= 2) e_col = mem[m_buf[i]][r][(q - 2) / 2];
                        if (q % 2 == 0 && q < 64) begin
                            do_addr = 1'b1;
                            e_addr  = {m_buf[i], 4'(r), 5'(q / 2)};
                        end
                    end else begin
                        e_ad = 4'(r);
                        if (q < 66 + bl) begin
                            e_col = mem[m_buf[i]][r][31];
                        end else if (q == 66 + bl) begin
                            e_lat = 1'b1;
                            e_col = mem[m_buf[i]][r][31];
                        end else begin
                            e_oe = 1'b0;
                            e_fd = (r == 15) && (q == per - 1);
                        end
                    end
                end
                e_ack = e_fd && swap_req;

                chk("oe", i, int'(oe[i]), int'(e_oe));
                chk("lat", i, int'(lat[i]), int'(e_lat));
                chk("led_clk", i, int'(led[i]), int'(e_led));
                chk("row_sel", i, int'(ad[i]), int'(e_ad));
                chk("colour", i, int'(col[i]), int'(e_col));
                chk("frame_done", i, int'(fd[i]), int'(e_fd));
                chk("swap_ack", i, int'(ack[i]), int'(e_ack));
                chk("buf_sel", i, int'(bsel[i]), int'(m_buf[i]));
                if (do_addr) chk("rd_addr", i, int'(addr[i]), int'(e_addr));

                if (!reset_n) begin
                    m_run[i] = 1'b0; m_p[i] = 0; m_buf[i] = 1'b0; m_ad[i] = '0;
                end else if (!m_run[i]) begin
                    if (enable) begin
                        m_run[i] = 1'b1;
                        m_p[i]   = 0;
                    end
                end else begin
                    if (m_p[i] % per == 65) m_ad[i] = 4'(m_p[i] / per);
                    if (m_p[i] == 16 * per - 1) begin
                        if (swap_req) m_buf[i] = ~m_buf[i];
                        m_p[i] = 0;
                        if (!enable) begin
                            m_run[i] = 1'b0;
                            m_ad[i]  = '0;
                        end
                    end else begin
                        m_p[i]++;
                    end
                end
            end
        end
    end

    // Literal timing expectations for the first row and first frames.
    int cyc = 0;
    int first_led = -1;
    int led_cnt = 0;
    logic lat_seen = 1'b0;
    logic oe_done0 = 1'b0;
    logic oe_done1 = 1'b0;
    int oe_run0 = 0;
    int oe_run1 = 0;
    int fd_n0 = 0, fd_n1 = 0, last_fd0 = 0, last_fd1 = 0;

    always @(negedge clk) begin
        if (checking && reset_n) begin
            cyc++;
            if (!lat_seen) begin
                if (led[0]) begin
                    led_cnt++;
                    if (first_led < 0) first_led = cyc;
                end
                if (lat[0]) begin
                    lat_seen = 1'b1;
                    chk("lat_after_first_led", 0, cyc - first_led, 65);
                    chk("led_pulses_row0", 0, led_cnt, 32);
                end
            end else if (!oe_done0) begin
                if (!oe[0]) oe_run0++;
                else if (oe_run0 > 0) begin
                    chk("oe_low_len", 0, oe_run0, 64);
                    oe_done0 = 1'b1;
                end
            end
            if (!oe_done1) begin
                if (!oe[1]) oe_run1++;
                else if (oe_run1 > 0) begin
                    chk("oe_low_len", 1, oe_run1, 1);
                    oe_done1 = 1'b1;
                end
            end
            if (fd[0]) begin
                if (fd_n0 == 0) chk("first_frame_done", 0, cyc - first_led, 2124);
                if (fd_n0 == 1) chk("frame_period", 0, cyc - last_fd0, 2128);
                fd_n0++;
                last_fd0 = cyc;
            end
            if (fd[1]) begin
                if (fd_n1 == 1) chk("frame_period", 1, cyc - last_fd1, 1104);
                fd_n1++;
                last_fd1 = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic found;
        for (int bs = 0; bs < 2; bs++)
            for (int rw = 0; rw < 16; rw++)
                for (int cl = 0; cl < 32; cl++)
                    mem[bs][rw][cl] = 6'($urandom);

        reset_n = 1'b0; enable = 1'b0; swap_req = 1'b0; checking = 1'b0;
        step();
        checking = 1'b1;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (5) step();
        enable = 1'b1;

        repeat (500) step();
        swap_req = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 4000 && !found; n++) begin
            step();
            if (ack[0]) found = 1'b1;
        end
        if (!found) timeout("first_swap");
        step();
        chk("buf_after_swap", 0, int'(bsel[0]), 1);
        chk("addr_msb_frame1", 0, int'(addr[0][9]), 1);
        found = 1'b0;
        for (int n = 0; n < 2300 && !found; n++) begin
            step();
            if (ack[0]) found = 1'b1;
        end
        if (!found) timeout("second_swap");
        step();
        swap_req = 1'b0;
        chk("buf_toggle_back", 0, int'(bsel[0]), 0);

        found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            step();
            if (ad[0] == 4'd7 && !oe[0]) found = 1'b1;
        end
        if (!found) timeout("reach_row7");
        enable = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            step();
            if (fd[0]) found = 1'b1;
        end
        if (!found) timeout("frame_done_after_disable");
        step();
        chk("idle_oe", 0, int'(oe[0]), 1);
        chk("idle_led_clk", 0, int'(led[0]), 0);
        chk("idle_lat", 0, int'(lat[0]), 0);
        repeat (20) step();
        enable = 1'b1;

        swap_req = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 4000 && !found; n++) begin
            step();
            if (ack[0]) found = 1'b1;
        end
        if (!found) timeout("third_swap");
        step();
        swap_req = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            step();
            if (ad[0] == 4'd9 && !oe[0]) found = 1'b1;
        end
        if (!found) timeout("reach_row9");
        chk("buf_before_reset", 0, int'(bsel[0]), 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("reset_buf_sel", 0, int'(bsel[0]), 0);
        chk("reset_oe", 0, int'(oe[0]), 1);
        chk("reset_addr", 0, int'(addr[0]), 0);

        repeat (6000) begin
            step();
            reset_n = ($urandom_range(0, 2999) != 0);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if (ack[0] || ack[1]) swap_req = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 499) == 0) swap_req = 1'b1;
        end
        reset_n = 1'b1;
        enable = 1'b1;
        swap_req = 1'b0;
        repeat (2500) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
